bcx_nonce_scheduler: RTL and testbench

Work-unit scheduler for the pipelined SHA processor chain. Accepts one block header work unit (midstate, tail words w1..w3) through a valid/ready handshake and drives the head of the processor chain. It issues one valid round per cycle, asserting newblock on the first round, until the nonce space is swept or a processor reports victory. It tracks in-flight rounds against the fixed pipeline latency, reconstructs the winning nonce from round index and processor number, and returns a single result record per work unit.

---
 rtl/bcx_nonce_scheduler.sv | 141 ++++++++++++++
 tb/tb_bcx_nonce_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bcx_nonce_scheduler.sv
// Work-unit scheduler at the head of the pipelined SHA chain: issues one round per
// cycle, tracks in-flight rounds, and reports the first winning nonce or exhaustion.
module bcx_nonce_scheduler #(
  parameter int          PARTITIONBITS = 1,
  parameter int          LATENCY       = 132,
  parameter logic [31:0] LAST_ROUND    = 32'((64'd1 << (32 - PARTITIONBITS)) - 64'd1),
  localparam int         NPROC         = 2 ** PARTITIONBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             work_valid,
  output logic             work_ready,
  input  logic [255:0]     work_hashstate,
  input  logic [31:0]      work_w1,
  input  logic [31:0]      work_w2,
  input  logic [31:0]      work_w3,
  input  logic             abort,
  output logic             chain_valid,
  output logic             chain_newblock,
  output logic [255:0]     chain_hashstate,
  output logic [31:0]      chain_w1,
  output logic [31:0]      chain_w2,
  output logic [31:0]      chain_w3,
  input  logic [NPROC-1:0] proc_victory,
  output logic             result_valid,
  output logic             result_found,
  output logic [31:0]      result_nonce
);
  localparam int RW = 32 - PARTITIONBITS;
  localparam logic [RW-1:0]      LAST_R = LAST_ROUND[RW-1:0];
  localparam logic [LATENCY-1:0] TOP    = LATENCY'(1) << (LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state;
  logic [LATENCY-1:0]       vld_pipe;
  logic [RW-1:0]            issue_round;
  logic [RW-1:0]            result_round;
  logic                     won;
  logic                     kill;
  logic [31:0]              win_nonce;
  logic [PARTITIONBITS-1:0] win_p;
  logic                     dvalid;
  logic                     capture;
  logic                     drain_last;

  assign dvalid = vld_pipe[LATENCY-1];
  // The final in-flight round is at the output this cycle, so the line is empty next cycle.
  assign drain_last = (vld_pipe & ~TOP) == '0;

  always_comb begin
    win_p = '0;
    for (int i = NPROC - 1; i >= 0; i--)
      if (proc_victory[i]) win_p = PARTITIONBITS'(i);
  end

  assign capture = dvalid && (|proc_victory) && !won && !kill &&
                   (state == ISSUE || state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      work_ready      <= 1'b1;
      chain_valid     <= 1'b0;
      chain_newblock  <= 1'b0;
      chain_hashstate <= '0;
      chain_w1        <= '0;
      chain_w2        <= '0;
      chain_w3        <= '0;
      result_valid    <= 1'b0;
      result_found    <= 1'b0;
      result_nonce    <= '0;
      vld_pipe        <= '0;
      issue_round     <= '0;
      result_round    <= '0;
      won             <= 1'b0;
      kill            <= 1'b0;
      win_nonce       <= '0;
    end else begin
      vld_pipe       <= (vld_pipe << 1) | LATENCY'(chain_valid);
      chain_newblock <= 1'b0;
      result_valid   <= 1'b0;
      if (dvalid) result_round <= result_round + RW'(1);
      if (capture) begin
        won       <= 1'b1;
        win_nonce <= {result_round, win_p};
      end

      case (state)
        IDLE: begin
          if (work_valid) begin
            chain_hashstate <= work_hashstate;
            chain_w1        <= work_w1;
            chain_w2        <= work_w2;
            chain_w3        <= work_w3;
            issue_round     <= '0;
            result_round    <= '0;
            won             <= 1'b0;
            kill            <= 1'b0;
            work_ready      <= 1'b0;
            chain_valid     <= 1'b1;
            chain_newblock  <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          issue_round <= issue_round + RW'(1);
          if (abort) begin
            kill        <= 1'b1;
            chain_valid <= 1'b0;
            state       <= DRAIN;
          end else if (capture || issue_round == LAST_R) begin
            chain_valid <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) kill <= 1'b1;
          if (drain_last) begin
            if (kill || abort) begin
              work_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              result_valid <= 1'b1;
              result_found <= won || capture;
              result_nonce <= won ? win_nonce :
                              capture ? {result_round, win_p} : 32'd0;
              state        <= DONE;
            end
          end
        end
        default: begin
          result_found <= 1'b0;
          result_nonce <= '0;
          work_ready   <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcx_nonce_scheduler.sv
// Directed + randomized bench for bcx_nonce_scheduler; expectations come from a
// round-level model of issue, win selection, abort and drain timing.
module tb_bcx_nonce_scheduler;
  localparam int LAT  = 4;
  localparam int LAST = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_hashstate;
  logic [31:0]  work_w1, work_w2, work_w3;
  logic         abort;
  logic         chain_valid, chain_newblock;
  logic [255:0] chain_hashstate;
  logic [31:0]  chain_w1, chain_w2, chain_w3;
  logic [1:0]   proc_victory;
  logic         result_valid, result_found;
  logic [31:0]  result_nonce;

  int total = 0;
  int bad   = 0;

  logic [1:0] vic [0:LAST];
  int         abort_k;

  bcx_nonce_scheduler #(.PARTITIONBITS(1), .LATENCY(LAT), .LAST_ROUND(32'd7)) dut (
    .clk(clk), .rst(rst),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_hashstate(work_hashstate), .work_w1(work_w1), .work_w2(work_w2), .work_w3(work_w3),
    .abort(abort),
    .chain_valid(chain_valid), .chain_newblock(chain_newblock),
    .chain_hashstate(chain_hashstate), .chain_w1(chain_w1), .chain_w2(chain_w2), .chain_w3(chain_w3),
    .proc_victory(proc_victory),
    .result_valid(result_valid), .result_found(result_found), .result_nonce(result_nonce)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_work();
    for (int i = 0; i < 8; i++) work_hashstate[i*32 +: 32] = $urandom;
    work_w1 = $urandom;
    work_w2 = $urandom;
    work_w3 = $urandom;
  endtask

  // Runs one work unit using the module-level vic[] table and abort_k.
  task automatic run_unit(input string name, input bit expect_ready_now);
    logic [255:0] hs;
    logic [31:0]  w1, w2, w3;
    int win_r, n_iss, n_last, exp_res_k, exp_rdy_k, waited;
    bit killed, exp_found, data_ok;
    logic [31:0] exp_nonce;
    int cv_cnt, cv_first, cv_last, nb_cnt, nb_k, res_cnt, res_k, rdy_k;
    logic got_found;
    logic [31:0] got_nonce;

    // Model: a round's victory counts only if that round was issued; the first
    // non-zero round wins, issue stops LAT rounds after it, abort cuts issue/kills.
    win_r = -1;
    for (int r = 0; r <= LAST; r++)
      if (vic[r] != 2'b00 && win_r < 0) win_r = r;
    n_iss = (win_r < 0) ? LAST : ((win_r + LAT < LAST) ? win_r + LAT : LAST);
    n_last = (abort_k >= 1 && abort_k <= n_iss + 1) ? abort_k - 1 : n_iss;
    killed = abort_k >= 1 && abort_k <= n_last + LAT + 1;
    exp_found = !killed && win_r >= 0;
    exp_nonce = exp_found ? {31'(win_r), vic[win_r][0] ? 1'b0 : 1'b1} : 32'd0;
    exp_res_k = killed ? -1 : n_last + LAT + 2;
    exp_rdy_k = killed ? n_last + LAT + 2 : n_last + LAT + 3;

    waited = 0;
    while (!work_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({name, ":ready"}, longint'(work_ready), 1);
    if (expect_ready_now) chk({name, ":ready_now"}, longint'(waited), 0);

    rand_work();
    hs = work_hashstate; w1 = work_w1; w2 = work_w2; w3 = work_w3;
    work_valid = 1'b1;
    @(negedge clk);
    work_valid = 1'b0;
    rand_work();

    cv_cnt = 0; cv_first = -1; cv_last = -1; nb_cnt = 0; nb_k = -1;
    res_cnt = 0; res_k = -1; rdy_k = -1; data_ok = 1'b1;
    got_found = 1'b0; got_nonce = '0;
    for (int k = 1; k <= LAST + LAT + 6; k++) begin
      if (chain_valid) begin
        cv_cnt++;
        if (cv_first < 0) cv_first = k;
        cv_last = k;
        if (chain_hashstate !== hs || chain_w1 !== w1 || chain_w2 !== w2 || chain_w3 !== w3)
          data_ok = 1'b0;
      end
      if (chain_newblock) begin nb_cnt++; nb_k = k; end
      if (result_valid) begin
        res_cnt++; res_k = k; got_found = result_found; got_nonce = result_nonce;
      end
      if (work_ready && rdy_k < 0) rdy_k = k;
      // Table value on this round's return cycle, random noise everywhere else.
      if (k - 1 - LAT >= 0 && k - 1 - LAT <= LAST) proc_victory = vic[k - 1 - LAT];
      else proc_victory = 2'($urandom);
      abort = (k == abort_k);
      @(negedge clk);
    end
    abort = 1'b0;
    proc_victory = 2'b00;

    chk({name, ":cv_first"}, longint'(cv_first), 1);
    chk({name, ":cv_last"},  longint'(cv_last),  longint'(n_last + 1));
    chk({name, ":cv_cnt"},   longint'(cv_cnt),   longint'(n_last + 1));
    chk({name, ":nb_cnt"},   longint'(nb_cnt),   1);
    chk({name, ":nb_k"},     longint'(nb_k),     1);
    chk({name, ":data"},     longint'(data_ok),  1);
    chk({name, ":res_cnt"},  longint'(res_cnt),  killed ? 0 : 1);
    chk({name, ":res_k"},    longint'(res_k),    longint'(exp_res_k));
    if (!killed) begin
      chk({name, ":found"}, longint'(got_found), longint'(exp_found));
      chk({name, ":nonce"}, longint'(got_nonce), longint'(exp_nonce));
    end
    chk({name, ":rdy_k"}, longint'(rdy_k), longint'(exp_rdy_k));
  endtask

  task automatic clear_vic();
    for (int r = 0; r <= LAST; r++) vic[r] = 2'b00;
  endtask

  initial begin
    rst = 1'b1; work_valid = 1'b0; abort = 1'b0; proc_victory = 2'b00;
    rand_work();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst:work_ready",   longint'(work_ready),      1);
    chk("rst:chain_valid",  longint'(chain_valid),     0);
    chk("rst:newblock",     longint'(chain_newblock),  0);
    chk("rst:result_valid", longint'(result_valid),    0);
    chk("rst:result_found", longint'(result_found),    0);
    chk("rst:result_nonce", longint'(result_nonce),    0);
    chk("rst:chain_w1",     longint'(chain_w1),        0);
    repeat (6) @(negedge clk);

    // Full sweep; abort pulsed during the result cycle must be ignored.
    clear_vic(); abort_k = LAST + LAT + 2;
    run_unit("nowin", 1'b0);

    clear_vic(); vic[3] = 2'b10; abort_k = 0;
    run_unit("win_r3p1", 1'b0);

    clear_vic(); vic[2] = 2'b11; vic[4] = 2'b01; abort_k = 0;
    run_unit("win_r2_first", 1'b0);

    clear_vic(); vic[LAST] = 2'b01; abort_k = 0;
    run_unit("win_last", 1'b0);

    clear_vic(); abort_k = 3;
    run_unit("abort_issue", 1'b0);

    clear_vic(); vic[1] = 2'b01; abort_k = 10;
    run_unit("abort_drain", 1'b0);

    // Reset in the middle of ISSUE, then a new unit the cycle after release.
    rand_work();
    work_valid = 1'b1;
    @(negedge clk);
    work_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst:chain_valid",  longint'(chain_valid),  0);
    chk("midrst:result_valid", longint'(result_valid), 0);
    chk("midrst:work_ready",   longint'(work_ready),   1);
    clear_vic(); vic[1] = 2'b01; abort_k = 0;
    run_unit("after_rst", 1'b1);

    for (int n = 0; n < 12; n++) begin
      for (int r = 0; r <= LAST; r++)
        vic[r] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      abort_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAST + LAT + 3)) : 0;
      run_unit($sformatf("rand%0d", n), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
